// File: rtl/wb_mem_tester_if.sv
// Wishbone bus bundle between the memory tester (master) and a memory slave.
interface wb_mem_tester_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_mem_tester.sv
// Wishbone memory tester: writes seed ^ {~i, i} to every word of a window,
// reads it back and compares, reporting pass / timeout / error count and the
// first failing byte address.
// Optional macro WB_MEM_TESTER_INVERT_PASS_EN adds a second write+read pass
// using the inverted pattern so every bit is exercised at both polarities.
module wb_mem_tester #(
  parameter int unsigned words_log2 = 8,
  parameter logic [31:0] base_adr   = 32'h0000_0000,
  parameter int unsigned timeout    = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     seed,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            tmo,
  output logic [15:0]     err_count,
  output logic [31:0]     err_adr,
  wb_mem_tester_if.master wb
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;

  localparam logic [16:0] NWORDS   = 17'd1 << words_log2;
  localparam logic [15:0] LAST_IDX = 16'(NWORDS - 17'd1);
  localparam logic [15:0] TMO_LIM  = 16'(timeout);

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        inv_q, inv_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
  logic [15:0] errc_q, errc_d;
  logic [31:0] erra_q, erra_d;

  logic ack_v, tmo_hit, last;

  function automatic logic [31:0] pattern(input logic [31:0] s, input logic [15:0] i,
                                          input logic inv);
    return s ^ {~i, i} ^ {32{inv}};
  endfunction

  function automatic logic [31:0] word_adr(input logic [15:0] i);
    return base_adr + {14'd0, i, 2'b00};
  endfunction

  // An ack only counts while our strobe is up; stray acks in gaps are ignored.
  assign ack_v   = wb.wb_ack_i & stb_q;
  assign tmo_hit = (tcnt_q == TMO_LIM - 16'd1);
  assign last    = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = WR_REQ;
      WR_REQ: begin
        if (ack_v)        state_d = WR_GAP;
        else if (tmo_hit) state_d = DONE;
      end
      WR_GAP: state_d = last ? RD_REQ : WR_REQ;
      RD_REQ: begin
        if (ack_v)        state_d = RD_GAP;
        else if (tmo_hit) state_d = DONE;
      end
      RD_GAP: begin
        if (!last)        state_d = RD_REQ;
`ifdef WB_MEM_TESTER_INVERT_PASS_EN
        else if (!inv_q)  state_d = WR_REQ;
`endif
        else              state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic: next value of every registered output
  always_comb begin
    idx_d  = idx_q;  seed_d = seed_q; inv_d  = inv_q;  tcnt_d = tcnt_q;
    cyc_d  = cyc_q;  stb_d  = stb_q;  we_d   = we_q;
    adr_d  = adr_q;  dat_d  = dat_q;
    busy_d = busy_q; done_d = done_q; pass_d = pass_q; tmo_d  = tmo_q;
    errc_d = errc_q; erra_d = erra_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          seed_d = seed;  idx_d  = '0;  inv_d = 1'b0; tcnt_d = '0;
          errc_d = '0;    erra_d = '0;  pass_d = 1'b0; tmo_d = 1'b0;
          done_d = 1'b0;  busy_d = 1'b1;
          cyc_d  = 1'b1;  stb_d  = 1'b1; we_d  = 1'b1;
          adr_d  = word_adr(16'd0);
          dat_d  = pattern(seed, 16'd0, 1'b0);
        end
      end
      WR_REQ, RD_REQ: begin
        if (ack_v) begin
          cyc_d = 1'b0; stb_d = 1'b0; we_d = 1'b0;
          if (state_q == RD_REQ && wb.wb_dat_i != pattern(seed_q, idx_q, inv_q)) begin
            if (errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
            if (errc_q == 16'd0)    erra_d = adr_q;
          end
        end else if (tmo_hit) begin
          cyc_d  = 1'b0; stb_d  = 1'b0; we_d   = 1'b0;
          tmo_d  = 1'b1; pass_d = 1'b0; busy_d = 1'b0; done_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      WR_GAP: begin
        tcnt_d = '0; cyc_d = 1'b1; stb_d = 1'b1;
        if (last) begin
          idx_d = '0; we_d = 1'b0; adr_d = word_adr(16'd0);
        end else begin
          idx_d = idx_q + 16'd1; we_d = 1'b1;
          adr_d = word_adr(idx_q + 16'd1);
          dat_d = pattern(seed_q, idx_q + 16'd1, inv_q);
        end
      end
      RD_GAP: begin
        tcnt_d = '0;
        if (!last) begin
          idx_d = idx_q + 16'd1; cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b0;
          adr_d = word_adr(idx_q + 16'd1);
        end
`ifdef WB_MEM_TESTER_INVERT_PASS_EN
        else if (!inv_q) begin
          inv_d = 1'b1; idx_d = '0;
          cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1;
          adr_d = word_adr(16'd0);
          dat_d = pattern(seed_q, 16'd0, 1'b1);
        end
`endif
        else begin
          busy_d = 1'b0; done_d = 1'b1; pass_d = (errc_q == 16'd0);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;   seed_q <= '0;   inv_q  <= 1'b0; tcnt_q <= '0;
      cyc_q  <= 1'b0; stb_q  <= 1'b0; we_q   <= 1'b0;
      adr_q  <= '0;   dat_q  <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0; tmo_q  <= 1'b0;
      errc_q <= '0;   erra_q <= '0;
    end else begin
      idx_q  <= idx_d;  seed_q <= seed_d; inv_q  <= inv_d;  tcnt_q <= tcnt_d;
      cyc_q  <= cyc_d;  stb_q  <= stb_d;  we_q   <= we_d;
      adr_q  <= adr_d;  dat_q  <= dat_d;
      busy_q <= busy_d; done_q <= done_d; pass_q <= pass_d; tmo_q  <= tmo_d;
      errc_q <= errc_d; erra_q <= erra_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_dat_o = dat_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign tmo         = tmo_q;
  assign err_count   = errc_q;
  assign err_adr     = erra_q;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Bench for wb_mem_tester: configurable Wishbone memory slave, bus scoreboard,
// table of complete test runs plus mid-test reset sequence.
`timescale 1ns/1ps
module tb_wb_mem_tester;
  localparam int NW = 16;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, tmo;
  logic [15:0] err_count;
  logic [31:0] err_adr;

  wb_mem_tester_if wb();

  wb_mem_tester #(.words_log2(4), .base_adr(32'h0), .timeout(10)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .tmo(tmo),
    .err_count(err_count), .err_adr(err_adr), .wb(wb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    logic [15:0] w;
    w = 16'(i);
    return s ^ {~w, w};
  endfunction

  // ---- slave model ----
  int          lat = 0;
  bit          stuck_en = 1'b0, noack_en = 1'b0, stray_en = 1'b0;
  logic [31:0] mem [NW];
  int          wcnt = 0;
  logic        req, ack_c;
  logic [31:0] rd;

  assign req = wb.wb_cyc_o & wb.wb_stb_o;

  always_comb begin
    ack_c = 1'b0;
    if (req) ack_c = !noack_en && (wcnt == lat);
    else     ack_c = stray_en;
  end

  always_comb begin
    rd = mem[wb.wb_adr_o[5:2]];
    if (stuck_en && wb.wb_adr_o == 32'h8) rd[7] = 1'b0;
  end

  assign wb.wb_ack_i = ack_c;
  assign wb.wb_dat_i = rd;

  always @(posedge clk) begin
    if (req && !ack_c) wcnt <= wcnt + 1;
    else               wcnt <= 0;
    if (req && ack_c && wb.wb_we_o) mem[wb.wb_adr_o[5:2]] <= wb.wb_dat_o;
  end

  // ---- scoreboard ----
  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } xfer_t;
  xfer_t exp_q[$];

  always @(negedge clk) begin
    xfer_t e;
    if (!reset && req && ack_c) begin
      if (exp_q.size() == 0) chk("xfer_extra", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("xfer_we",  32'(wb.wb_we_o), 32'(e.we));
        chk("xfer_adr", wb.wb_adr_o, e.adr);
        if (e.we) chk("xfer_wdat", wb.wb_dat_o, e.dat);
        chk("xfer_sel", 32'(wb.wb_sel_o), 32'hF);
      end
    end
  end

  task automatic push_all(input logic [31:0] s);
    for (int i = 0; i < NW; i++) exp_q.push_back('{1'b1, 32'(i * 4), pat(s, i)});
    for (int i = 0; i < NW; i++) exp_q.push_back('{1'b0, 32'(i * 4), 32'h0});
  endtask

  // One full test: returns cycles from start acceptance to done and strobe-high cycles.
  task automatic run(input logic [31:0] s, input int l, input bit stk, input bit na,
                     input bit stray, input bit repulse, output int cyc, output int stb_cnt);
    lat = l; stuck_en = stk; noack_en = na; stray_en = stray;
    if (!na) push_all(s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    cyc = 0; stb_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = repulse && (cyc == 20 || cyc == 40);
      seed  = repulse ? 32'hFFFF_FFFF : s;
      if (wb.wb_stb_o) stb_cnt++;
      if (cyc == 1) chk("busy_run", 32'(busy), 32'd1);
    end while (!done && cyc < 1000);
    start = 1'b0;
    if (!done) chk("done_reached", 32'd0, 32'd1);
    cyc = cyc - 1;
    chk("xfer_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [31:0] seed; int lat; bit stuck; bit noack; bit stray; bit repulse;
    bit e_pass; bit e_tmo; logic [15:0] e_err; logic [31:0] e_adr; int e_cyc; int e_stb;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int c, sc;
    bit hit;
    vecs[0] = '{32'hA5A5_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'h0,  64,  32};
    vecs[1] = '{32'h0000_00FF, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 32'h8,  64,  32};
    vecs[2] = '{32'h1234_5678, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'h0, 128,  96};
    vecs[3] = '{32'hDEAD_BEEF, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 32'h8,  96,  64};
    vecs[4] = '{32'h0000_0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'h0,  10,  10};
    vecs[5] = '{32'hA5A5_0000, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'h0,  64,  32};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc",  32'(wb.wb_cyc_o), 32'd0);
    chk("rst_stb",  32'(wb.wb_stb_o), 32'd0);
    chk("rst_we",   32'(wb.wb_we_o),  32'd0);
    chk("rst_adr",  wb.wb_adr_o, 32'd0);
    chk("rst_dat",  wb.wb_dat_o, 32'd0);
    chk("rst_sel",  32'(wb.wb_sel_o), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_tmo",  32'(tmo),  32'd0);
    chk("rst_errc", 32'(err_count), 32'd0);
    chk("rst_erra", err_adr, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run(vecs[v].seed, vecs[v].lat, vecs[v].stuck, vecs[v].noack, vecs[v].stray,
          vecs[v].repulse, c, sc);
      chk($sformatf("v%0d_cycles", v), 32'(c),  32'(vecs[v].e_cyc));
      chk($sformatf("v%0d_stb", v),    32'(sc), 32'(vecs[v].e_stb));
      chk($sformatf("v%0d_done", v),   32'(done), 32'd1);
      chk($sformatf("v%0d_busy", v),   32'(busy), 32'd0);
      chk($sformatf("v%0d_pass", v),   32'(pass), 32'(vecs[v].e_pass));
      chk($sformatf("v%0d_tmo", v),    32'(tmo),  32'(vecs[v].e_tmo));
      chk($sformatf("v%0d_errc", v),   32'(err_count), 32'(vecs[v].e_err));
      chk($sformatf("v%0d_erra", v),   err_adr, vecs[v].e_adr);
      chk($sformatf("v%0d_cyc_idle", v), 32'(wb.wb_cyc_o), 32'd0);
      if (v == 0) begin
        chk("mem_word3", mem[3], 32'h5A59_0003);
        chk("mem_word0", mem[0], 32'h5A5A_0000);
      end
    end

    // reset asserted while the tester waits in RD_REQ for word 3
    lat = 2; stuck_en = 1'b1; noack_en = 1'b0; stray_en = 1'b0;
    push_all(32'h0000_00FF);
    @(negedge clk);
    seed = 32'h0000_00FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      if (req && !wb.wb_we_o && wb.wb_adr_o == 32'hC) hit = 1'b1;
      else @(negedge clk);
    end
    chk("rdreq_seen", 32'(hit), 32'd1);
    chk("pre_rst_errc", 32'(err_count), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc",  32'(wb.wb_cyc_o), 32'd0);
    chk("mid_rst_stb",  32'(wb.wb_stb_o), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_errc", 32'(err_count), 32'd0);
    chk("mid_rst_erra", err_adr, 32'd0);
    reset = 1'b0;
    exp_q.delete();

    // clean run after the mid-test reset
    run(32'h0F0F_3C3C, 0, 1'b0, 1'b0, 1'b0, 1'b0, c, sc);
    chk("post_rst_cycles", 32'(c), 32'd64);
    chk("post_rst_pass",   32'(pass), 32'd1);
    chk("post_rst_mem5",   mem[5], 32'h0F0F_3C3C ^ 32'hFFFA_0005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
